raster_scheduler: RTL and testbench

Front-end controller for the triangle rasterizer. It queues triangle descriptors from the MicroBlaze and launches the rasterizer one triangle at a time with a start/done handshake. It also runs a frame-clear engine that fills the frame buffer with a background colour and the Z-buffer with far depth. It owns the frame-buffer and Z-buffer write ports and multiplexes them between the rasterizer and the clear engine.

---
 rtl/raster_scheduler.sv | 156 +++++++++++++++
 tb/tb_raster_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_scheduler.sv
// Triangle-launch front end: queues descriptors, runs the rasterizer one triangle at a time,
// and owns the frame/Z-buffer write ports shared between the rasterizer and the clear engine.
module raster_scheduler #(
  parameter int         DEPTH     = 4,
  parameter int         DESC_W    = 236,
  parameter int         FB_PIXELS = 76800,
  parameter logic [7:0] Z_FAR     = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tri_valid,
  output logic                       tri_ready,
  input  logic [DESC_W-1:0]          tri_desc,
  input  logic                       clear_req,
  input  logic [7:0]                 clear_color,
  output logic                       clear_done,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] tri_count,
  output logic [DESC_W-1:0]          rast_desc,
  output logic                       rast_start,
  input  logic                       rast_done,
  input  logic                       rast_fb_we,
  input  logic [7:0]                 rast_fb_din,
  input  logic [16:0]                rast_fb_addr,
  input  logic                       rast_zb_we,
  input  logic [7:0]                 rast_zb_din,
  input  logic [16:0]                rast_zb_addr,
  output logic                       fb_we,
  output logic [7:0]                 fb_din,
  output logic [16:0]                fb_addr,
  output logic                       zb_en,
  output logic                       zb_we,
  output logic [7:0]                 zb_din,
  output logic [16:0]                zb_addr
);

  localparam int          CW        = $clog2(DEPTH + 1);
  localparam int          PW        = $clog2(DEPTH);
  localparam logic [16:0] LAST_ADDR = 17'(FB_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, CLEAR} state_e;

  state_e            state_q;
  logic [DESC_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              clear_pending_q;
  logic [7:0]        color_q;
  logic [16:0]       clr_addr_q;
  logic [DESC_W-1:0] rast_desc_q;
  logic              rast_start_q;
  logic              clear_done_q;
  logic              push, pop;

  assign tri_ready = (count_q != CW'(DEPTH));
  assign push      = tri_valid && tri_ready;
  assign pop       = (state_q == IDLE) && !clear_pending_q && (count_q != '0);

  assign tri_count  = count_q;
  assign rast_desc  = rast_desc_q;
  assign rast_start = rast_start_q;
  assign clear_done = clear_done_q;
  assign busy       = (count_q != '0) || clear_pending_q || (state_q != IDLE);

  // NOTE: the descriptor storage has no reset; a slot is always written before it is
  // read, and keeping it out of the reset tree lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tri_desc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      clear_pending_q <= 1'b0;
      color_q         <= '0;
      clr_addr_q      <= '0;
      rast_desc_q     <= '0;
      rast_start_q    <= 1'b0;
      clear_done_q    <= 1'b0;
    end else begin
      rast_start_q <= 1'b0;
      clear_done_q <= 1'b0;

      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);

      // A request arriving while a clear is queued or running only refreshes the colour.
      if (clear_req) color_q <= clear_color;
      if (clear_req && state_q != CLEAR) clear_pending_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (clear_pending_q) begin
            state_q         <= CLEAR;
            clr_addr_q      <= '0;
            clear_pending_q <= 1'b0;
          end else if (pop) begin
            rast_desc_q  <= mem_q[rd_ptr_q];
            rast_start_q <= 1'b1;
            state_q      <= LAUNCH;
          end
        end
        LAUNCH: state_q <= RUN;
        RUN: begin
          if (rast_done) state_q <= IDLE;
        end
        CLEAR: begin
          clr_addr_q <= clr_addr_q + 17'd1;
          if (clr_addr_q == LAST_ADDR) begin
            state_q      <= IDLE;
            clear_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory-port ownership: rasterizer pass-through in RUN, fill pattern in CLEAR, idle otherwise.
  always_comb begin
    fb_we   = 1'b0;
    fb_din  = '0;
    fb_addr = '0;
    zb_en   = 1'b0;
    zb_we   = 1'b0;
    zb_din  = '0;
    zb_addr = '0;
    case (state_q)
      RUN: begin
        fb_we   = rast_fb_we;
        fb_din  = rast_fb_din;
        fb_addr = rast_fb_addr;
        zb_en   = 1'b1;
        zb_we   = rast_zb_we;
        zb_din  = rast_zb_din;
        zb_addr = rast_zb_addr;
      end
      CLEAR: begin
        fb_we   = 1'b1;
        fb_din  = color_q;
        fb_addr = clr_addr_q;
        zb_en   = 1'b1;
        zb_we   = 1'b1;
        zb_din  = Z_FAR;
        zb_addr = clr_addr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_raster_scheduler.sv
// Self-checking bench for raster_scheduler: vector table, directed clear/launch sequences,
// and a randomized run scored against a timestamp-based model of the launch rules.
module tb_raster_scheduler;

  localparam int DEPTH     = 4;
  localparam int DESC_W    = 236;
  localparam int FB_PIXELS = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              tri_valid;
  logic              tri_ready;
  logic [DESC_W-1:0] tri_desc;
  logic              clear_req;
  logic [7:0]        clear_color;
  logic              clear_done;
  logic              busy;
  logic [2:0]        tri_count;
  logic [DESC_W-1:0] rast_desc;
  logic              rast_start;
  logic              rast_done;
  logic              rast_fb_we, rast_zb_we;
  logic [7:0]        rast_fb_din, rast_zb_din;
  logic [16:0]       rast_fb_addr, rast_zb_addr;
  logic              fb_we, zb_en, zb_we;
  logic [7:0]        fb_din, zb_din;
  logic [16:0]       fb_addr, zb_addr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  raster_scheduler #(.DEPTH(DEPTH), .DESC_W(DESC_W), .FB_PIXELS(FB_PIXELS), .Z_FAR(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_desc(tri_desc),
    .clear_req(clear_req), .clear_color(clear_color), .clear_done(clear_done),
    .busy(busy), .tri_count(tri_count),
    .rast_desc(rast_desc), .rast_start(rast_start), .rast_done(rast_done),
    .rast_fb_we(rast_fb_we), .rast_fb_din(rast_fb_din), .rast_fb_addr(rast_fb_addr),
    .rast_zb_we(rast_zb_we), .rast_zb_din(rast_zb_din), .rast_zb_addr(rast_zb_addr),
    .fb_we(fb_we), .fb_din(fb_din), .fb_addr(fb_addr),
    .zb_en(zb_en), .zb_we(zb_we), .zb_din(zb_din), .zb_addr(zb_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic zero_inputs();
    tri_valid    = 1'b0;
    tri_desc     = '0;
    clear_req    = 1'b0;
    clear_color  = '0;
    rast_done    = 1'b0;
    rast_fb_we   = 1'b0;
    rast_fb_din  = '0;
    rast_fb_addr = '0;
    rast_zb_we   = 1'b0;
    rast_zb_din  = '0;
    rast_zb_addr = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, tri_ready, 1);
    check({tag, "_count"}, tri_count, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start_done"}, {rast_start, clear_done}, 0);
    check({tag, "_desc"}, rast_desc, 0);
    check({tag, "_ports"}, {fb_we, zb_we, zb_en, fb_din, fb_addr, zb_din, zb_addr}, 0);
  endtask

  task automatic do_reset();
    zero_inputs();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [DESC_W-1:0] rand_desc();
    logic [255:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DESC_W-1:0];
  endfunction

  typedef struct {
    logic valid;
    int   din;
    logic done;
    logic e_start;
    int   e_count;
    logic e_ready;
    logic e_busy;
    int   e_desc;
  } vec_t;

  typedef struct {
    logic [DESC_W-1:0] d;
    int                t;
  } ent_t;

  logic [DESC_W-1:0] dv [7];
  vec_t              tbl [11];

  initial begin
    rst = 1'b1;
    zero_inputs();
    for (int i = 0; i < 6; i++) dv[i] = rand_desc();
    dv[6] = '0;

    // ---- Full queue with a stalled rasterizer; one done frees a slot ----
    // index 6 in e_desc selects the all-zero descriptor seen before any launch
    tbl[0]  = '{1'b1, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 6};
    tbl[1]  = '{1'b1, 1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 6};
    tbl[2]  = '{1'b1, 2, 1'b0, 1'b1, 1, 1'b1, 1'b1, 0};
    tbl[3]  = '{1'b1, 3, 1'b0, 1'b0, 2, 1'b1, 1'b1, 0};
    tbl[4]  = '{1'b1, 4, 1'b0, 1'b0, 3, 1'b1, 1'b1, 0};
    tbl[5]  = '{1'b1, 5, 1'b0, 1'b0, 4, 1'b0, 1'b1, 0};
    tbl[6]  = '{1'b1, 5, 1'b0, 1'b0, 4, 1'b0, 1'b1, 0};
    tbl[7]  = '{1'b1, 5, 1'b1, 1'b0, 4, 1'b0, 1'b1, 0};
    tbl[8]  = '{1'b1, 5, 1'b0, 1'b0, 4, 1'b0, 1'b1, 0};
    tbl[9]  = '{1'b1, 5, 1'b0, 1'b1, 3, 1'b1, 1'b1, 1};
    tbl[10] = '{1'b0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      tri_valid = tbl[i].valid;
      tri_desc  = dv[tbl[i].din];
      rast_done = tbl[i].done;
      #1;
      check($sformatf("tbl%0d_start", i), rast_start, tbl[i].e_start);
      check($sformatf("tbl%0d_count", i), tri_count, tbl[i].e_count);
      check($sformatf("tbl%0d_ready", i), tri_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("tbl%0d_desc", i), rast_desc, dv[tbl[i].e_desc]);
      tick();
    end

    // ---- Three triangles, done 20 cycles after each start ----
    do_reset();
    begin
      int nstarts    = 0;
      int last_start = -1000;
      int last_done  = -1000;
      for (int c = 0; c < 120; c++) begin
        tri_valid = (c < 3);
        tri_desc  = (c < 3) ? dv[c] : '0;
        rast_done = (nstarts > 0) && (c == last_start + 20);
        #1;
        if (rast_start) begin
          if (nstarts < 3) check($sformatf("seq_desc%0d", nstarts), rast_desc, dv[nstarts]);
          if (nstarts == 0) check("seq_first_start_cycle", c, 2);
          else check($sformatf("seq_gap%0d", nstarts), c - last_done, 2);
          last_start = c;
          nstarts++;
        end
        if (rast_done) begin
          last_done = c;
          if (nstarts == 3) check("seq_busy_at_last_done", busy, 1);
        end
        if (nstarts == 3 && c == last_done + 1) check("seq_busy_after_last_done", busy, 0);
        tick();
      end
      check("seq_num_starts", nstarts, 3);
    end

    // ---- Clear of 16 pixels, with a repeated request mid-clear ----
    do_reset();
    begin
      int nwrites = 0;
      for (int c = 0; c < 26; c++) begin
        clear_req   = (c == 0) || (c == 6);
        clear_color = 8'h3C;
        #1;
        check($sformatf("clr_we_c%0d", c), {fb_we, zb_we, zb_en}, (c >= 2 && c <= 17) ? 3'b111 : 3'b000);
        check($sformatf("clr_addr_c%0d", c), {fb_addr, zb_addr},
              (c >= 2 && c <= 17) ? {17'(c - 2), 17'(c - 2)} : 34'd0);
        check($sformatf("clr_data_c%0d", c), {fb_din, zb_din}, (c >= 2 && c <= 17) ? 16'h3CFF : 16'h0000);
        check($sformatf("clr_done_c%0d", c), clear_done, c == 18);
        check($sformatf("clr_busy_c%0d", c), busy, c >= 1 && c <= 17);
        if (fb_we) nwrites++;
        tick();
      end
      clear_req = 1'b0;
      check("clr_total_writes", nwrites, 16);
    end

    // ---- Clear requested while rasterizing with two triangles queued ----
    do_reset();
    for (int c = 0; c < 31; c++) begin
      tri_valid    = (c < 3);
      tri_desc     = (c < 3) ? dv[c] : '0;
      clear_req    = (c == 5);
      clear_color  = 8'h77;
      rast_done    = (c == 7);
      rast_fb_we   = (c == 5 || c == 6);
      rast_fb_din  = (c == 5) ? 8'hA5 : 8'h5A;
      rast_fb_addr = (c == 5) ? 17'h01234 : 17'h1ABCD;
      rast_zb_we   = (c == 5);
      rast_zb_din  = 8'h42;
      rast_zb_addr = 17'h04321;
      #1;
      if (c == 5) begin
        check("mix_run_fb", {fb_we, fb_din, fb_addr}, {1'b1, 8'hA5, 17'h01234});
        check("mix_run_zb", {zb_en, zb_we, zb_din, zb_addr}, {1'b1, 1'b1, 8'h42, 17'h04321});
        check("mix_run_count", tri_count, 2);
      end
      if (c == 6) check("mix_run_fb2", {fb_we, fb_din, fb_addr, zb_we}, {1'b1, 8'h5A, 17'h1ABCD, 1'b0});
      if (c >= 8) begin
        check($sformatf("mix_start_c%0d", c), rast_start, c == 26);
        check($sformatf("mix_we_c%0d", c), fb_we, c >= 9 && c <= 24);
        check($sformatf("mix_done_c%0d", c), clear_done, c == 25);
        if (c >= 9 && c <= 24) check($sformatf("mix_clr_c%0d", c), {fb_din, fb_addr}, {8'h77, 17'(c - 9)});
      end
      if (c == 20) check("mix_desc_held", rast_desc, dv[0]);
      if (c == 26) check("mix_desc_next", rast_desc, dv[1]);
      tick();
    end
    zero_inputs();

    // ---- Reset in the middle of a clear, then a fresh clear ----
    do_reset();
    for (int c = 0; c < 9; c++) begin
      clear_req   = (c == 0);
      clear_color = 8'h11;
      #1;
      tick();
    end
    clear_req = 1'b0;
    #1;
    check("mid_addr_before_rst", {fb_we, fb_addr}, {1'b1, 17'd7});
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    rst = 1'b0;
    begin
      int stray = 0;
      for (int c = 0; c < 20; c++) begin
        #1;
        if (fb_we || zb_we || busy) stray++;
        tick();
      end
      check("mid_no_writes_after_rst", stray, 0);
    end
    for (int c = 0; c < 3; c++) begin
      clear_req   = (c == 0);
      clear_color = 8'h22;
      #1;
      if (c == 2) check("mid_restart_addr0", {fb_we, fb_addr, fb_din}, {1'b1, 17'd0, 8'h22});
      tick();
    end
    zero_inputs();
    for (int c = 0; c < 20; c++) tick();

    // ---- Randomized launches against a timestamp model ----
    do_reset();
    begin
      ent_t              mq[$];
      logic [DESC_W-1:0] mdesc    = '0;
      bit                outst    = 0;
      int                s_cyc    = 0;
      int                ready_at = 0;
      int                launches = 0;
      for (int c = 0; c < 2000; c++) begin
        bit   e_start;
        bit   in_run;
        int   e_count;
        e_start = 0;
        if (!outst && c >= ready_at && mq.size() > 0 && mq[0].t + 2 <= c) begin
          e_start = 1;
          mdesc   = mq[0].d;
          void'(mq.pop_front());
          outst   = 1;
          s_cyc   = c;
          launches++;
        end
        in_run  = outst && (c > s_cyc);
        e_count = mq.size();

        tri_valid    = ($urandom_range(0, 9) < 6);
        tri_desc     = rand_desc();
        rast_done    = in_run ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) == 0);
        rast_fb_we   = $urandom_range(0, 1);
        rast_fb_din  = 8'($urandom());
        rast_fb_addr = 17'($urandom());
        rast_zb_we   = $urandom_range(0, 1);
        rast_zb_din  = 8'($urandom());
        rast_zb_addr = 17'($urandom());
        #1;
        check("rnd_start", rast_start, e_start);
        check("rnd_desc", rast_desc, mdesc);
        check("rnd_count", tri_count, e_count);
        check("rnd_ready", tri_ready, e_count != DEPTH);
        check("rnd_busy", busy, (e_count > 0) || outst);
        if (in_run)
          check("rnd_ports_run", {fb_we, fb_din, fb_addr, zb_en, zb_we, zb_din, zb_addr},
                {rast_fb_we, rast_fb_din, rast_fb_addr, 1'b1, rast_zb_we, rast_zb_din, rast_zb_addr});
        else
          check("rnd_ports_idle", {fb_we, fb_din, fb_addr, zb_en, zb_we, zb_din, zb_addr}, 0);

        if (tri_valid && e_count != DEPTH) mq.push_back('{tri_desc, c});
        if (in_run && rast_done) begin
          outst    = 0;
          ready_at = c + 2;
        end
        tick();
      end
      check("rnd_some_launches", launches > 50, 1);
    end

    zero_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
